// File: rtl/c_pmon.sv
// Power-good supervisor for a regulator output rail.
// Tracks ramp-up, asserts pgood after a settle window, latches UV/OV/timeout faults.
module c_pmon #(
  parameter int uv_th = 450,
  parameter int ov_th = 550,
  parameter int hyst  = 10,
  parameter int tdly  = 100,
  parameter int tdeg  = 3,
  parameter int tto   = 2000
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic [15:0] vin,
  input  logic        en,
  output logic        pgood,
  output logic        fault,
  output logic [1:0]  fcode,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_GOOD = 2'd2,
    S_FLT  = 2'd3
  } st_t;

  localparam logic signed [16:0] UV_T  = 17'(uv_th);
  localparam logic signed [16:0] OV_T  = 17'(ov_th);
  localparam logic signed [16:0] UV_LO = 17'(uv_th - hyst);
  localparam logic signed [16:0] OV_HI = 17'(ov_th + hyst);
  localparam logic [15:0] DLY_L = 16'(tdly - 1);
  localparam logic [15:0] DEG_L = 16'(tdeg - 1);
  localparam logic [15:0] TTO_L = 16'(tto - 1);

  st_t st, st_n;
  logic [15:0] win_cnt, win_n;
  logic [15:0] tmo_cnt, tmo_n;
  logic [15:0] deg_cnt, deg_n;
  logic [1:0]  fc_n;

  logic signed [16:0] vx;
  logic in_win, r_ov, g_uv, g_ov, g_bad;

  assign vx     = {vin[15], vin};
  assign in_win = (vx >= UV_T) && (vx <= OV_T);
  assign r_ov   = vx > OV_T;
  assign g_uv   = vx < UV_LO;
  assign g_ov   = vx > OV_HI;
  assign g_bad  = g_uv | g_ov;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    st_n  = st;
    fc_n  = fcode;
    win_n = win_cnt;
    tmo_n = tmo_cnt;
    deg_n = deg_cnt;
    if (!en) begin
      st_n  = S_OFF;
      fc_n  = 2'd0;
      win_n = '0;
      tmo_n = '0;
      deg_n = '0;
    end else begin
      unique case (st)
        S_OFF: begin
          st_n  = S_RAMP;
          fc_n  = 2'd0;
          win_n = '0;
          tmo_n = '0;
          deg_n = '0;
        end
        S_RAMP: begin
          tmo_n = sat_inc(tmo_cnt);
          win_n = in_win ? sat_inc(win_cnt) : '0;
          deg_n = r_ov ? sat_inc(deg_cnt) : '0;
          if (r_ov && deg_cnt == DEG_L) begin
            st_n = S_FLT;
            fc_n = 2'd2;
          end else if (in_win && win_cnt == DLY_L) begin
            st_n = S_GOOD;
          end else if (tmo_cnt == TTO_L) begin
            st_n = S_FLT;
            fc_n = 2'd3;
          end
          if (st_n != S_RAMP) begin
            win_n = '0;
            tmo_n = '0;
            deg_n = '0;
          end
        end
        S_GOOD: begin
          deg_n = g_bad ? sat_inc(deg_cnt) : '0;
          if (g_bad && deg_cnt == DEG_L) begin
            st_n  = S_FLT;
            fc_n  = g_uv ? 2'd1 : 2'd2;
            deg_n = '0;
          end
        end
        S_FLT: ;
        default: st_n = S_OFF;
      endcase
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      st      <= S_OFF;
      fcode   <= 2'd0;
      pgood   <= 1'b0;
      fault   <= 1'b0;
      win_cnt <= '0;
      tmo_cnt <= '0;
      deg_cnt <= '0;
    end else begin
      st      <= st_n;
      fcode   <= fc_n;
      pgood   <= (st_n == S_GOOD);
      fault   <= (st_n == S_FLT);
      win_cnt <= win_n;
      tmo_cnt <= tmo_n;
      deg_cnt <= deg_n;
    end
  end

  assign state = st;

endmodule
